// File: rtl/perf_counter_unit_pkg.sv
// Shared constants for the performance counter unit: counter indices,
// state encodings and the per-counter increment-enable helper.
package perf_counter_unit_pkg;

    localparam int unsigned NUM_COUNTERS = 4;

    localparam int unsigned CNT_CYCLES = 0;
    localparam int unsigned CNT_STALL  = 1;
    localparam int unsigned CNT_BRANCH = 2;
    localparam int unsigned CNT_MISS   = 3;

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    typedef logic [NUM_COUNTERS-1:0] cnt_mask_t;

    // A miss only counts when a branch actually resolved in the same cycle.
    function automatic cnt_mask_t count_enables(
        input logic run,
        input logic stall,
        input logic br_resolved,
        input logic br_miss
    );
        cnt_mask_t m;
        m             = '0;
        m[CNT_CYCLES] = run;
        m[CNT_STALL]  = run & stall;
        m[CNT_BRANCH] = run & br_resolved;
        m[CNT_MISS]   = run & br_resolved & br_miss;
        return m;
    endfunction

endpackage

// File: rtl/perf_counter_unit_if.sv
// Indexed read port of the performance counter unit: request/select in,
// one-cycle-latency valid/data response out.
interface perf_counter_unit_if #(
    parameter int WIDTH    = 32,
    parameter int SEL_BITS = 2
);
    logic                rd_req;
    logic [SEL_BITS-1:0] rd_sel;
    logic                rd_valid;
    logic [WIDTH-1:0]    rd_data;

    modport master (
        output rd_req,
        output rd_sel,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_sel,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/perf_counter_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; ovf pulses on any cycle an
// increment is requested while the count already sits at its maximum.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             ovf
);

    logic at_max;

    assign at_max = (q == '1);
    assign ovf    = en & ~clr & at_max;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && !at_max) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/perf_counter_unit.sv
// CPU performance counters (cycles, stalls, branches, misses) with halt
// freeze, clear, sticky saturation flag and a latency-1 indexed read port.
module perf_counter_unit
    import perf_counter_unit_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SEL_BITS = 2
) (
    input  logic                  input_clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  br_resolved,
    input  logic                  br_miss,
    input  logic                  hlt,
    input  logic                  clear,
    perf_counter_unit_if.slave    rd,
    output logic [WIDTH-1:0]      cycles_consumed,
    output logic [WIDTH-1:0]      StallCount,
    output logic [WIDTH-1:0]      BranchPredictionCount,
    output logic [WIDTH-1:0]      BranchPredictionMissCount,
    output logic                  halted,
    output logic                  sat
);

    logic [0:0]       state;
    logic             count_run;
    cnt_mask_t        cnt_en;
    cnt_mask_t        cnt_ovf;
    logic [WIDTH-1:0] cnt_q [NUM_COUNTERS];
    logic [WIDTH-1:0] sel_value;

    // The hlt cycle and the clear cycle are deliberately not counted.
    assign count_run = (state == RUN) & ~hlt & ~clear;
    assign cnt_en    = count_enables(count_run, stall, br_resolved, br_miss);

    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
        sat_counter #(
            .WIDTH (WIDTH)
        ) u_cnt (
            .clk (input_clk),
            .rst (rst),
            .en  (cnt_en[i]),
            .clr (clear),
            .q   (cnt_q[i]),
            .ovf (cnt_ovf[i])
        );
    end

    assign cycles_consumed           = cnt_q[CNT_CYCLES];
    assign StallCount                = cnt_q[CNT_STALL];
    assign BranchPredictionCount     = cnt_q[CNT_BRANCH];
    assign BranchPredictionMissCount = cnt_q[CNT_MISS];

    assign halted = (state == HALTED);

    always_ff @(posedge input_clk) begin
        if (!rst) begin
            state <= RUN;
        end else if (clear) begin
            state <= RUN;
        end else if (state == RUN && hlt) begin
            state <= HALTED;
        end
    end

    always_ff @(posedge input_clk) begin
        if (!rst || clear) begin
            sat <= 1'b0;
        end else if (|cnt_ovf) begin
            sat <= 1'b1;
        end
    end

    always_comb begin
        sel_value = '0;
        case (rd.rd_sel)
            SEL_BITS'(CNT_CYCLES): sel_value = cnt_q[CNT_CYCLES];
            SEL_BITS'(CNT_STALL):  sel_value = cnt_q[CNT_STALL];
            SEL_BITS'(CNT_BRANCH): sel_value = cnt_q[CNT_BRANCH];
            SEL_BITS'(CNT_MISS):   sel_value = cnt_q[CNT_MISS];
            default:               sel_value = '0;
        endcase
    end

    // Sampling the registers here returns the pre-edge value, so counting
    // or clearing in the request cycle never leaks into the response.
    always_ff @(posedge input_clk) begin
        if (!rst) begin
            rd.rd_valid <= 1'b0;
            rd.rd_data  <= '0;
        end else begin
            rd.rd_valid <= rd.rd_req;
            if (rd.rd_req) begin
                rd.rd_data <= sel_value;
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed self-checking bench for perf_counter_unit: a 32-bit instance for
// the functional cases and a 4-bit instance for saturation.
module tb_perf_counter_unit;

    logic clk = 1'b0;
    logic rst, stall, br_resolved, br_miss, hlt, clear;

    logic [31:0] a_cyc, a_stall, a_br, a_miss;
    logic        a_halted, a_sat;
    logic [3:0]  b_cyc, b_stall, b_br, b_miss;
    logic        b_halted, b_sat;

    int n_checks = 0;
    int n_pass   = 0;

    perf_counter_unit_if #(.WIDTH(32), .SEL_BITS(2)) ifa ();
    perf_counter_unit_if #(.WIDTH(4),  .SEL_BITS(2)) ifb ();

    perf_counter_unit #(.WIDTH(32), .SEL_BITS(2)) dut_a (
        .input_clk                 (clk),
        .rst                       (rst),
        .stall                     (stall),
        .br_resolved               (br_resolved),
        .br_miss                   (br_miss),
        .hlt                       (hlt),
        .clear                     (clear),
        .rd                        (ifa),
        .cycles_consumed           (a_cyc),
        .StallCount                (a_stall),
        .BranchPredictionCount     (a_br),
        .BranchPredictionMissCount (a_miss),
        .halted                    (a_halted),
        .sat                       (a_sat)
    );

    perf_counter_unit #(.WIDTH(4), .SEL_BITS(2)) dut_b (
        .input_clk                 (clk),
        .rst                       (rst),
        .stall                     (stall),
        .br_resolved               (br_resolved),
        .br_miss                   (br_miss),
        .hlt                       (hlt),
        .clear                     (clear),
        .rd                        (ifb),
        .cycles_consumed           (b_cyc),
        .StallCount                (b_stall),
        .BranchPredictionCount     (b_br),
        .BranchPredictionMissCount (b_miss),
        .halted                    (b_halted),
        .sat                       (b_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; br_resolved = 0; br_miss = 0; hlt = 0; clear = 0;
    endtask

    task automatic check_a(input string tag, input int c, input int s, input int b, input int m);
        check({tag, ".cyc"},   a_cyc,   c);
        check({tag, ".stall"}, a_stall, s);
        check({tag, ".br"},    a_br,    b);
        check({tag, ".miss"},  a_miss,  m);
    endtask

    initial begin
        rst = 0; idle();
        ifa.rd_req = 0; ifa.rd_sel = 0;
        ifb.rd_req = 0; ifb.rd_sel = 0;

        // 1: reset hold, 10 idle cycles, mid-run reset
        step(); step();
        check_a("rst", 0, 0, 0, 0);
        check("rst.halted", a_halted, 0);
        check("rst.sat", a_sat, 0);
        check("rst.rd_valid", ifa.rd_valid, 0);
        check("rst.rd_data", ifa.rd_data, 0);
        rst = 1;
        for (int i = 0; i < 10; i++) step();
        check_a("idle10", 10, 0, 0, 0);
        check("idle10.halted", a_halted, 0);
        stall = 1; br_resolved = 1; hlt = 1; rst = 0;
        step();
        check_a("midrst", 0, 0, 0, 0);
        check("midrst.halted", a_halted, 0);
        idle(); rst = 1;

        // 2: mixed strobes over 20 cycles; br_miss alone on 2 cycles
        for (int i = 0; i < 20; i++) begin
            stall       = (i < 5);
            br_resolved = (i >= 5 && i < 9);
            br_miss     = (i == 5) || (i == 12) || (i == 13);
            step();
        end
        idle();
        check_a("mix20", 20, 5, 4, 1);
        clear = 1; step(); clear = 0;
        check_a("clear", 0, 0, 0, 0);

        // 3: hlt after 7 cycles, then 50 halted cycles with noise
        for (int i = 0; i < 7; i++) step();
        hlt = 1; stall = 1; br_resolved = 1;
        step();
        check("hlt.halted", a_halted, 1);
        check_a("hlt", 7, 0, 0, 0);
        hlt = 0;
        for (int i = 0; i < 50; i++) begin
            br_miss = i[0];
            hlt     = (i == 20);
            step();
        end
        idle();
        check_a("held50", 7, 0, 0, 0);
        check("held50.halted", a_halted, 1);

        // 4: hlt and clear together while HALTED
        hlt = 1; clear = 1;
        step();
        idle();
        check_a("hltclr", 0, 0, 0, 0);
        check("hltclr.halted", a_halted, 0);
        step();
        check("resume.cyc", a_cyc, 1);

        // 5: 4-bit instance saturates at 15
        clear = 1; step(); clear = 0;
        for (int i = 0; i < 15; i++) step();
        check("w4.cyc15", b_cyc, 15);
        check("w4.sat_at_max", b_sat, 0);
        step();
        check("w4.cyc16", b_cyc, 15);
        check("w4.sat16", b_sat, 1);
        step();
        check("w4.cyc17", b_cyc, 15);
        check("w4.sat17", b_sat, 1);
        check("w32.cyc17", a_cyc, 17);
        check("w32.sat", a_sat, 0);
        clear = 1; step(); clear = 0;
        check("w4.clr.cyc", b_cyc, 0);
        check("w4.clr.sat", b_sat, 0);

        // 6: back-to-back reads; counts reach 9,3,2,2 first
        for (int i = 0; i < 9; i++) begin
            stall       = (i < 3);
            br_resolved = (i == 3 || i == 4);
            br_miss     = (i == 3 || i == 4);
            step();
        end
        check_a("pre_rd", 9, 3, 2, 2);
        ifa.rd_req = 1; ifa.rd_sel = 0; stall = 1; br_resolved = 1; br_miss = 1;
        step();
        check("rd0.valid", ifa.rd_valid, 1);
        check("rd0.data", ifa.rd_data, 9);
        ifa.rd_sel = 1; stall = 1; br_resolved = 0; br_miss = 0;
        step();
        check("rd1.valid", ifa.rd_valid, 1);
        check("rd1.data", ifa.rd_data, 4);
        ifa.rd_sel = 3; stall = 0; br_resolved = 1; br_miss = 1;
        step();
        check("rd2.valid", ifa.rd_valid, 1);
        check("rd2.data", ifa.rd_data, 3);
        ifa.rd_req = 0; idle();
        step();
        check("rd_idle.valid", ifa.rd_valid, 0);
        check("rd_idle.data", ifa.rd_data, 3);
        check_a("post_rd", 13, 5, 4, 4);

        // read in the clear cycle returns pre-clear value
        ifa.rd_req = 1; ifa.rd_sel = 0; clear = 1;
        step();
        ifa.rd_req = 0; clear = 0;
        check("rdclr.valid", ifa.rd_valid, 1);
        check("rdclr.data", ifa.rd_data, 13);
        check("rdclr.cyc", a_cyc, 0);

        // reset wins while HALTED
        hlt = 1; step(); hlt = 0;
        check("halt2.halted", a_halted, 1);
        rst = 0; step(); rst = 1;
        check("rst_halted.halted", a_halted, 0);
        check("rst_halted.rd_valid", ifa.rd_valid, 0);
        check("rst_halted.rd_data", ifa.rd_data, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/perf_counter_unit.md
Name: perf_counter_unit

Overview:
- Owns the CPU-side performance counters that the simulation bench reads at end of run: cycles consumed, stall count, branch-prediction count and branch-miss count.
- Sits inside PL_CPU and watches the stall, branch-resolve and halt strobes from the pipeline.
- Freezes all counts when hlt retires.
- Also serves an indexed read port so counters can be sampled mid-run without disturbing counting.

Parameters:
- WIDTH, 32, width of every counter and of rd_data.
- SEL_BITS, 2, width of rd_sel (four counters).

Ports:
- input_clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low: while rst==0 at a rising edge, the block resets.
- stall  in  1  pipeline stalled this cycle (StallDetectionUnit output).
- br_resolved  in  1  a predicted branch resolved this cycle.
- br_miss  in  1  the resolving branch was mispredicted; meaningful only with br_resolved.
- hlt  in  1  hlt instruction retired this cycle (one-cycle pulse).
- clear  in  1  zero all counters and resume counting.
- rd_req  in  1  read request, one-cycle pulse.
- rd_sel  in  SEL_BITS  counter select: 0 cycles, 1 stall, 2 branch, 3 miss.
- cycles_consumed  out  WIDTH  live cycle count.
- StallCount  out  WIDTH  live stall count.
- BranchPredictionCount  out  WIDTH  live branch count.
- BranchPredictionMissCount  out  WIDTH  live miss count.
- halted  out  1  high in HALTED state.
- sat  out  1  sticky flag: some counter has saturated.
- rd_valid  out  1  read response strobe.
- rd_data  out  WIDTH  read response data.

Behaviour:
- Reset (rst==0 at an edge):
  - All counters, sat, rd_valid and rd_data go to 0; halted goes to 0; state goes to RUN.
  - Reset wins over every other input, including mid-read and while HALTED.
- States: RUN, HALTED.
  - RUN -> HALTED when hlt==1 and clear==0.
  - HALTED -> RUN only on clear==1.
  - hlt while already HALTED is ignored.
- Counting in RUN, on cycles where hlt==0 and clear==0:
  - cycles_consumed += 1 every cycle.
  - StallCount += stall.
  - BranchPredictionCount += br_resolved.
  - BranchPredictionMissCount += (br_resolved & br_miss).
  - br_miss without br_resolved is ignored.
- hlt cycle: nothing is counted, not even the cycle. The bench adds 1 for the hlt instruction, so this rule is fixed.
- In HALTED, all counters hold.
- clear, from either state:
  - All four counters and sat become 0 at the next edge; state becomes RUN.
  - The clear cycle itself is not counted.
  - clear and hlt in the same cycle: clear wins and the state is RUN.
- Saturation:
  - Each counter stops at 2^WIDTH-1 and never wraps.
  - sat is set in the cycle a counter would have exceeded its maximum, and stays set until clear or reset.
- Invariants: MissCount <= BranchPredictionCount <= cycles_consumed; StallCount <= cycles_consumed.
- Read port:
  - rd_req at edge N gives rd_valid=1 for exactly one cycle after edge N+1, i.e. latency 1.
  - rd_data is the selected counter's value before the edge-N update. The counting in the request cycle is not visible in the response.
  - Back-to-back requests every cycle are allowed: one response per request, in order.
  - rd_data holds its last value when rd_valid==0.
  - A request in the same cycle as clear returns the pre-clear value.
- Live count outputs are the counter registers themselves, with no extra latency.

Decomposition:
- Shared package/header (defines): the counter-index constants CNT_CYCLES=0, CNT_STALL=1, CNT_BRANCH=2, CNT_MISS=3, and the state encodings RUN=1'b0, HALTED=1'b1.
- One natural sub-module: sat_counter.
  - Parameter WIDTH.
  - Inputs en, clr. Outputs q and a one-cycle overflow-attempt strobe.
  - Instantiated four times; the top-level ORs the strobes into sat.

Test Plan:
1. Reset hold, then release and run 10 cycles with all strobes low -> cycles_consumed=10, other counters 0, halted=0; rst=0 mid-run -> all outputs 0 at the next edge.
2. 20 RUN cycles with stall high on 5 cycles, br_resolved on 4 cycles (br_miss on 1 of them), plus br_miss alone on 2 cycles -> cycles=20, Stall=5, Branch=4, Miss=1.
3. After 7 cycles, pulse hlt together with stall and br_resolved -> halted=1, cycles=7, Stall and Branch unchanged by that cycle; 50 further cycles -> all counts held at those values.
4. In HALTED, pulse hlt and clear in the same cycle -> all counters 0, halted=0, state RUN; counting resumes from 1 on the following cycle.
5. With WIDTH=4, run 17 cycles -> cycles_consumed sticks at 15 and sat=1; clear -> sat=0.
6. rd_req with rd_sel=0 when cycles=9, then back-to-back rd_sel=1 and rd_sel=3 -> rd_valid on three consecutive cycles with rd_data = 9, then the StallCount and MissCount values as they were before each request edge.
